// File: rtl/multi_issue_inst_fifo_if.sv
// Handshake bundle between fetch (master) and the multi-lane instruction FIFO (slave).
// Lane 0 is always the oldest instruction on both the enqueue and dequeue sides.
interface multi_issue_inst_fifo_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int ENQ_W  = 2,
   parameter int DEQ_W  = 2
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ENQ_W-1:0]        io_enqueue_valid;
   logic [ENQ_W*DATA_W-1:0] io_enqueue_bits;
   logic                    io_readyForEnqueue;
   logic [DEQ_W-1:0]        io_dequeue_ready;
   logic [DEQ_W-1:0]        io_dequeue_valid;
   logic [DEQ_W*DATA_W-1:0] io_dequeue_bits;
   logic [CNT_W-1:0]        io_count;

   modport slave (
      input  io_enqueue_valid,
      input  io_enqueue_bits,
      input  io_dequeue_ready,
      output io_readyForEnqueue,
      output io_dequeue_valid,
      output io_dequeue_bits,
      output io_count
   );

   modport master (
      output io_enqueue_valid,
      output io_enqueue_bits,
      output io_dequeue_ready,
      input  io_readyForEnqueue,
      input  io_dequeue_valid,
      input  io_dequeue_bits,
      input  io_count
   );
endinterface

// File: rtl/multi_issue_inst_fifo.sv
// Multi-lane instruction FIFO between fetch and decode.
// Accepts up to ENQ_W in-order instructions per cycle (all-or-nothing, gated by the
// registered occupancy) and presents the DEQ_W oldest entries to decode.
// All outputs depend on registered state only; there is no same-cycle bypass.
// Optional feature macro: INST_FIFO_FLUSH_EN adds io_flush, which empties the queue
// (pointers and count) without clearing storage.
module multi_issue_inst_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int ENQ_W  = 2,
   parameter int DEQ_W  = 2
) (
   input logic                    clock,
   input logic                    reset,
   multi_issue_inst_fifo_if.slave io
`ifdef INST_FIFO_FLUSH_EN
   ,
   input logic                    io_flush
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   // Highest occupancy at which a full ENQ_W-wide group still fits.
   localparam logic [CNT_W-1:0] ENQ_LIMIT = CNT_W'(DEPTH - ENQ_W);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  n_enq_s, n_acc_s, n_deq_s;
   logic              ready_s;
   logic [DEQ_W-1:0]  deq_valid_s;
   logic [DEQ_W-1:0]  deq_fire_s;

   // Enqueue readiness and thermometer-coded dequeue valids from the registered count.
   always_comb begin
      ready_s = (count_q <= ENQ_LIMIT);
      deq_valid_s = '0;
      for (int i = 0; i < DEQ_W; i++) begin
         deq_valid_s[i] = (count_q > CNT_W'(i));
      end
   end

   // Dequeue payloads read from head onward; invalid lanes are forced to zero.
   always_comb begin
      io.io_dequeue_bits = '0;
      for (int i = 0; i < DEQ_W; i++) begin
         if (deq_valid_s[i]) begin
            io.io_dequeue_bits[i*DATA_W +: DATA_W] = mem_q[head_q + PTR_W'(i)];
         end else begin
            io.io_dequeue_bits[i*DATA_W +: DATA_W] = '0;
         end
      end
   end

   // Count leading contiguous valid enqueue lanes; lanes past the first gap are ignored.
   always_comb begin
      logic run;
      run     = 1'b1;
      n_enq_s = '0;
      for (int i = 0; i < ENQ_W; i++) begin
         if (run && io.io_enqueue_valid[i]) begin
            n_enq_s = n_enq_s + CNT_W'(1);
         end else begin
            run = 1'b0;
         end
      end
      n_acc_s = ready_s ? n_enq_s : '0;
   end

   // Count leading contiguous dequeue handshakes (ready and valid) starting at lane 0.
   always_comb begin
      logic run;
      run        = 1'b1;
      n_deq_s    = '0;
      deq_fire_s = io.io_dequeue_ready & deq_valid_s;
      for (int i = 0; i < DEQ_W; i++) begin
         if (run && deq_fire_s[i]) begin
            n_deq_s = n_deq_s + CNT_W'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

   // Next pointer/count values; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      head_d  = head_q + PTR_W'(n_deq_s);
      tail_d  = tail_q + PTR_W'(n_acc_s);
      count_d = count_q + n_acc_s - n_deq_s;
   end

   // State update: reset beats flush, flush beats any same-cycle enqueue/dequeue.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`ifdef INST_FIFO_FLUSH_EN
      end else if (io_flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
`endif
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < ENQ_W; i++) begin
            if (CNT_W'(i) < n_acc_s) begin
               mem_q[tail_q + PTR_W'(i)] <= io.io_enqueue_bits[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign io.io_readyForEnqueue = ready_s;
   assign io.io_dequeue_valid   = deq_valid_s;
   assign io.io_count           = count_q;

endmodule
